// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative restoring divider.
// State encoding, default widths and the MIPS funct codes.
package seq_divider_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle between control unit and divider.
// Result fields feed the HI/LO registers.
interface seq_divider_if #(
    parameter int WIDTH = seq_divider_pkg::WIDTH_DEF
);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivByZero;

    modport master (
        output Start, Signed, Dividend, Divisor,
        input  Busy, Done, Quotient, Remainder, DivByZero
    );

    modport slave (
        input  Start, Signed, Dividend, Divisor,
        output Busy, Done, Quotient, Remainder, DivByZero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract.
// The extra top bit of the trial result is the borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_i, msb_i};
    assign trial   = shifted - {1'b0, dvs_i};
    assign q_o     = ~trial[WIDTH];
    assign rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Iterative 32-bit restoring divider for DIV/DIVU, one quotient bit per clock.
// Works on magnitudes and restores signs in a single fix-up cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave div_if
);
    state_e state_q, state_d;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic             div_zero;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             last;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // -2^31 negates to itself, which is the correct unsigned magnitude
    assign div_zero = (div_if.Divisor == '0);
    assign a_neg    = div_if.Signed & div_if.Dividend[WIDTH-1];
    assign b_neg    = div_if.Signed & div_if.Divisor[WIDTH-1];
    assign a_mag    = a_neg ? -div_if.Dividend : div_if.Dividend;
    assign b_mag    = b_neg ? -div_if.Divisor : div_if.Divisor;
    assign last     = (cnt_q == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .msb_i (quo_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (div_if.Start) begin
                    state_d = div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_if.Busy = (state_q == S_CALC) || (state_q == S_FIX);
        div_if.Done = (state_q == S_DONE);
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        quot_d = quot_q;
        remo_d = remo_q;
        dbz_d  = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (div_if.Start && div_zero) begin
                    quot_d = '1;
                    remo_d = div_if.Dividend;
                    dbz_d  = 1'b1;
                end else if (div_if.Start) begin
                    rem_d  = '0;
                    quo_d  = a_mag;
                    dvs_d  = b_mag;
                    cnt_d  = '0;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    dbz_d  = 1'b0;
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_FIX: begin
                quot_d = qneg_q ? -quo_q : quo_q;
                remo_d = rneg_q ? -rem_q : rem_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            quot_q <= '0;
            remo_q <= '0;
            dbz_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            quot_q <= quot_d;
            remo_q <= remo_d;
            dbz_q  <= dbz_d;
        end
    end

    assign div_if.Quotient  = quot_q;
    assign div_if.Remainder = remo_q;
    assign div_if.DivByZero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized bench for seq_divider.
// Expected results come from plain integer division in the bench.
module tb_seq_divider;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    seq_divider_if #(.WIDTH(32)) d ();

    seq_divider dut (
        .clk    (clk),
        .reset  (reset),
        .div_if (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic sg, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r,
                                  output logic dz);
        longint sa, sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            dz = 1'b0;
            if (sg) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = 32'(sa / sb);
                r  = 32'(sa % sb);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Start in cycle 0; returns at the sampling point of the Done cycle.
    task automatic do_op(input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input int pulse_at,
                         output int lat, output int busy_bad);
        bit got;
        @(negedge clk);
        d.Start = 1'b1;
        d.Signed = sg;
        d.Dividend = a;
        d.Divisor = b;
        @(posedge clk);
        #1;
        d.Start = 1'b0;
        d.Signed = 1'($urandom);
        d.Dividend = $urandom;
        d.Divisor = $urandom;
        lat = 1;
        busy_bad = 0;
        got = 1'b0;
        while (!got && lat <= 60) begin
            @(negedge clk);
            if (d.Done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (d.Busy !== 1'b1) busy_bad++;
                d.Start = (lat == pulse_at);
                if (lat == pulse_at) begin
                    d.Dividend = $urandom;
                    d.Divisor = $urandom_range(1, 100);
                end
                @(posedge clk);
                lat++;
            end
        end
        if (!got) lat = -1;
    endtask

    task automatic test_reset();
        total_cnt += 5;
        if (d.Busy !== 1'b0) $display("FAIL rst_busy got %b want 0", d.Busy);
        else pass_cnt++;
        if (d.Done !== 1'b0) $display("FAIL rst_done got %b want 0", d.Done);
        else pass_cnt++;
        if (d.Quotient !== 32'd0) $display("FAIL rst_quo got %h want 0", d.Quotient);
        else pass_cnt++;
        if (d.Remainder !== 32'd0) $display("FAIL rst_rem got %h want 0", d.Remainder);
        else pass_cnt++;
        if (d.DivByZero !== 1'b0) $display("FAIL rst_dbz got %b want 0", d.DivByZero);
        else pass_cnt++;
    endtask

    task automatic test_divu();
        int lat, bb;
        do_op(1'b0, 32'd100, 32'd7, -1, lat, bb);
        total_cnt += 7;
        if (lat != 34) $display("FAIL divu_lat got %0d want 34", lat);
        else pass_cnt++;
        if (d.Quotient !== 32'd14) $display("FAIL divu_quo got %h want 14", d.Quotient);
        else pass_cnt++;
        if (d.Remainder !== 32'd2) $display("FAIL divu_rem got %h want 2", d.Remainder);
        else pass_cnt++;
        if (d.DivByZero !== 1'b0) $display("FAIL divu_dbz got %b want 0", d.DivByZero);
        else pass_cnt++;
        if (bb != 0 || d.Busy !== 1'b0)
            $display("FAIL divu_busy got bad=%0d busy_at_done=%b want 0/0", bb, d.Busy);
        else pass_cnt++;
        @(negedge clk);
        if (d.Done !== 1'b0) $display("FAIL divu_done_pulse got %b want 0", d.Done);
        else pass_cnt++;
        if (d.Quotient !== 32'd14) $display("FAIL divu_hold got %h want 14", d.Quotient);
        else pass_cnt++;
    endtask

    task automatic test_div_signed();
        int lat, bb;
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, lat, bb);
        total_cnt += 3;
        if (lat != 34) $display("FAIL div_lat got %0d want 34", lat);
        else pass_cnt++;
        if (d.Quotient !== 32'hFFFF_FFFD)
            $display("FAIL div_quo got %h want fffffffd", d.Quotient);
        else pass_cnt++;
        if (d.Remainder !== 32'hFFFF_FFFF)
            $display("FAIL div_rem got %h want ffffffff", d.Remainder);
        else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int lat, bb;
        do_op(1'b0, 32'd123, 32'd0, -1, lat, bb);
        total_cnt += 6;
        if (lat != 1) $display("FAIL dz_lat got %0d want 1", lat);
        else pass_cnt++;
        if (d.Quotient !== 32'hFFFF_FFFF)
            $display("FAIL dz_quo got %h want ffffffff", d.Quotient);
        else pass_cnt++;
        if (d.Remainder !== 32'd123) $display("FAIL dz_rem got %h want 7b", d.Remainder);
        else pass_cnt++;
        if (d.DivByZero !== 1'b1) $display("FAIL dz_flag got %b want 1", d.DivByZero);
        else pass_cnt++;
        do_op(1'b0, 32'd10, 32'd5, -1, lat, bb);
        if (d.DivByZero !== 1'b0) $display("FAIL dz_clear got %b want 0", d.DivByZero);
        else pass_cnt++;
        if (d.Quotient !== 32'd2) $display("FAIL dz_next_quo got %h want 2", d.Quotient);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int lat, bb;
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bb);
        total_cnt += 4;
        if (d.Quotient !== 32'h8000_0000)
            $display("FAIL ovf_quo got %h want 80000000", d.Quotient);
        else pass_cnt++;
        if (d.Remainder !== 32'd0) $display("FAIL ovf_rem got %h want 0", d.Remainder);
        else pass_cnt++;
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bb);
        if (d.Quotient !== 32'd0) $display("FAIL ovfu_quo got %h want 0", d.Quotient);
        else pass_cnt++;
        if (d.Remainder !== 32'h8000_0000)
            $display("FAIL ovfu_rem got %h want 80000000", d.Remainder);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int lat, bb;
        do_op(1'b0, 32'd50, 32'd3, 10, lat, bb);
        total_cnt += 3;
        if (lat != 34) $display("FAIL ign_lat got %0d want 34", lat);
        else pass_cnt++;
        if (d.Quotient !== 32'd16) $display("FAIL ign_quo got %h want 10", d.Quotient);
        else pass_cnt++;
        if (d.Remainder !== 32'd2) $display("FAIL ign_rem got %h want 2", d.Remainder);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, bb;
        @(negedge clk);
        d.Start = 1'b1;
        d.Signed = 1'b0;
        d.Dividend = 32'd1000;
        d.Divisor = 32'd7;
        @(posedge clk);
        #1;
        d.Start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        total_cnt += 6;
        if (d.Busy !== 1'b1) $display("FAIL mid_busy_pre got %b want 1", d.Busy);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        if (d.Busy !== 1'b0 || d.Done !== 1'b0)
            $display("FAIL mid_ctl got busy=%b done=%b want 0/0", d.Busy, d.Done);
        else pass_cnt++;
        if (d.Quotient !== 32'd0) $display("FAIL mid_quo got %h want 0", d.Quotient);
        else pass_cnt++;
        if (d.Remainder !== 32'd0) $display("FAIL mid_rem got %h want 0", d.Remainder);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        do_op(1'b0, 32'd9, 32'd9, -1, lat, bb);
        if (d.Quotient !== 32'd1 || lat != 34)
            $display("FAIL post_quo got %h lat %0d want 1 lat 34", d.Quotient, lat);
        else pass_cnt++;
        if (d.Remainder !== 32'd0) $display("FAIL post_rem got %h want 0", d.Remainder);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic        sg;
        logic [31:0] a, b, eq, er;
        logic        edz;
        int          lat, bb, elat;
        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom);
            a = $urandom;
            if (i % 5 == 1) a = 32'($urandom_range(0, 50));
            case ($urandom % 4)
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 9));
                default: b = 32'($urandom_range(1, 1000));
            endcase
            if (i % 8 == 3) b = 32'd0;
            model(sg, a, b, eq, er, edz);
            elat = edz ? 1 : 34;
            do_op(sg, a, b, -1, lat, bb);
            total_cnt += 4;
            if (lat != elat) $display("FAIL rnd_lat i=%0d got %0d want %0d", i, lat, elat);
            else pass_cnt++;
            if (d.Quotient !== eq)
                $display("FAIL rnd_quo i=%0d s=%b %h/%h got %h want %h",
                         i, sg, a, b, d.Quotient, eq);
            else pass_cnt++;
            if (d.Remainder !== er)
                $display("FAIL rnd_rem i=%0d s=%b %h/%h got %h want %h",
                         i, sg, a, b, d.Remainder, er);
            else pass_cnt++;
            if (d.DivByZero !== edz)
                $display("FAIL rnd_dbz i=%0d got %b want %b", i, d.DivByZero, edz);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        reset = 1'b0;
        d.Start = 1'b0;
        d.Signed = 1'b0;
        d.Dividend = '0;
        d.Divisor = '0;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_divu();
        test_div_signed();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative 32-bit restoring divider. It is the inverse companion of the ALU multiply path and implements DIV/DIVU for the MIPS datapath.
- It accepts dividend and divisor through a start/busy/done handshake and produces one quotient bit per clock.
- Results go to the HI/LO registers: quotient to LO, remainder to HI.
- The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request; sampled only in IDLE.
- Signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with Start.
- Dividend  input  WIDTH  A operand; sampled with Start.
- Divisor  input  WIDTH  B operand; sampled with Start.
- Busy  output  1  high from the cycle after Start until Done.
- Done  output  1  one-cycle pulse; results valid in that cycle.
- Quotient  output  WIDTH  quotient (to LO); held until the next accepted Start.
- Remainder  output  WIDTH  remainder (to HI); held until the next accepted Start.
- DivByZero  output  1  set with Done when Divisor was 0; held with the results.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - Busy, Done, DivByZero = 0.
  - Quotient, Remainder = 0.
  - Counter and working registers = 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, Start=1, Divisor!=0:
  - Latch magnitudes: |Dividend| and |Divisor| if Signed, else the raw values.
  - Latch the sign flags: qneg = sign(A) xor sign(B); rneg = sign(A). Both are 0 when unsigned.
  - Clear the partial remainder; counter=0; go to CALC.
  - Clear DivByZero.
- IDLE, Start=1, Divisor==0:
  - Go directly to DONE.
  - Quotient=all ones; Remainder=Dividend unmodified; DivByZero=1.
- CALC, one step per cycle:
  - Shift {rem, quo} left by 1, bringing in the MSB of the dividend register.
  - trial = rem - divisor. If trial is non-negative, rem=trial and quo[0]=1; otherwise restore and quo[0]=0.
  - counter++. After WIDTH steps (counter==WIDTH-1 on the last step) go to FIX.
- FIX:
  - Quotient = qneg ? -quo : quo.
  - Remainder = rneg ? -rem : rem.
  - Go to DONE.
- DONE:
  - Done=1 for exactly one cycle, Busy=0, then go to IDLE.
  - Results and DivByZero hold until the next accepted Start.
- Latency: Start accepted at cycle 0 gives Done at cycle WIDTH+2 (34). The divide-by-zero case gives Done at cycle 1.
- Busy is 1 in CALC and FIX.
- Start while not in IDLE (CALC/FIX/DONE) is ignored. There is no queueing and no abort.
- Signed overflow, -2^31 / -1: Quotient=32'h80000000, Remainder=0. No flag; the result wraps naturally.
- Magnitude of -2^31 is taken as 32'h80000000 unsigned; the datapath is WIDTH+1 bits internally for the trial subtract.
- Remainder sign always follows the dividend; |Remainder| < |Divisor|.
- Reset asserted mid-operation: immediately IDLE with all outputs cleared. A Start coincident with reset release is ignored until reset is high at a clock edge.
- Operands may change after the Start cycle without effect.

Decomposition:
- Shared package / include file:
  - State encoding localparams: IDLE=2'b00, CALC=2'b01, FIX=2'b10, DONE=2'b11.
  - WIDTH default.
  - Funct codes DIV=6'h1A and DIVU=6'h1B, used by the control unit to drive Signed/Start.
- One sub-module: div_step. It is combinational: given rem, dividend MSB and divisor, it returns the next rem and the quotient bit. seq_divider instantiates it once and owns the FSM, counter and sign fix-up.

Test Plan:
- DIVU 100/7: Start with Signed=0 -> Done at cycle 34; Quotient=14, Remainder=2, DivByZero=0; Busy high cycles 1-33.
- DIV -7/2: Dividend=32'hFFFFFFF9, Divisor=2, Signed=1 -> Quotient=32'hFFFFFFFD (-3), Remainder=32'hFFFFFFFF (-1).
- Divide by zero: Dividend=123, Divisor=0 -> Done at cycle 1; Quotient=32'hFFFFFFFF, Remainder=123, DivByZero=1. A following 10/5 divide clears DivByZero and gives Quotient=2.
- Signed overflow: 32'h80000000 / 32'hFFFFFFFF -> Quotient=32'h80000000, Remainder=0. DIVU on the same operands -> Quotient=0, Remainder=32'h80000000.
- Start pulsed at cycle 10 of an active 50/3 divide -> ignored; Done still at cycle 34 with Quotient=16, Remainder=2.
- Reset driven low at cycle 15 of an active divide -> Busy, Done, Quotient, Remainder are 0 immediately (asynchronously); after release, 9/9 gives Quotient=1, Remainder=0.
